// File: rtl/router_in_port.sv
// router_in_port: mesh router input stage; flit FIFO, XY route decode, packet-locked request. Optional counter: ROUTER_IN_PORT_CNT_EN
module router_in_port #(
  parameter int         FIFO_DEPTH = 16,
  parameter int         PORT_WIDTH = 128,
  parameter logic [3:0] LOCAL_X    = 4'd0,
  parameter logic [3:0] LOCAL_Y    = 4'd0
)(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic [PORT_WIDTH-1:0]         s_tdata,
  input  logic                          s_tlast,
  output logic [4:0]                    req,
  input  logic [4:0]                    gnt,
  output logic [PORT_WIDTH-1:0]         out_msg,
  output logic                          out_last,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [15:0]                   flit_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {HEAD, BODY} state_t;
  state_t r_state, w_next;
  logic [PORT_WIDTH:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic [4:0] r_dir, w_route;
  logic [PORT_WIDTH:0] w_head;
  logic [3:0] w_dst_x, w_dst_y;
  logic w_push, w_pop;
  assign empty    = r_wptr == r_rptr;
  assign full     = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign level    = r_wptr - r_rptr;
  assign s_tready = !full;
  assign w_push   = s_tvalid && !full;
  assign w_pop    = |(req & gnt);
  assign w_head   = empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign {out_last, out_msg} = w_head;
  assign w_dst_x  = w_head[PORT_WIDTH-9 -: 4];
  assign w_dst_y  = w_head[PORT_WIDTH-13 -: 4];
  assign w_route  = w_dst_x > LOCAL_X ? 5'b00100 :
                    w_dst_x < LOCAL_X ? 5'b10000 :
                    w_dst_y > LOCAL_Y ? 5'b00010 :
                    w_dst_y < LOCAL_Y ? 5'b01000 : 5'b00001;
  // flit storage; tlast kept as the top bit of each entry
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {s_tlast, s_tdata};
  // read/write pointers, one extra wrap bit for full/empty disambiguation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  // state register; direction locked when a non-tail head flit leaves
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= HEAD;
      r_dir   <= 5'b00001;
    end else begin
      r_state <= w_next;
      if (w_pop && r_state == HEAD && !out_last) r_dir <= w_route;
    end
  // request decode on head flits, locked direction for the rest of the packet
  always_comb begin
    req    = empty ? 5'b00000 : (r_state == HEAD ? w_route : r_dir);
    w_next = w_pop ? (out_last ? HEAD : BODY) : r_state;
  end
`ifdef ROUTER_IN_PORT_CNT_EN
  logic [15:0] r_cnt;
  // saturating count of forwarded flits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (w_pop && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 1'b1;
  assign flit_cnt = r_cnt;
`else
  assign flit_cnt = '0;
`endif
endmodule

// File: tb/tb_router_in_port.sv
// tb_router_in_port: directed self-checking bench for router_in_port at local (2,1)
module tb_router_in_port;
  logic clk = 0, rst_n = 0, s_tvalid = 0, s_tlast = 0;
  logic s_tready, out_last, full, empty;
  logic [127:0] s_tdata = '0, out_msg;
  logic [4:0] req, gnt = '0, level;
  logic [15:0] flit_cnt;
  int total = 0, bad = 0;
`ifdef ROUTER_IN_PORT_CNT_EN
  localparam int N_BULK = 70000;
  localparam logic [15:0] CNT_MID = 16'd1, CNT_END = 16'hFFFF;
`else
  localparam int N_BULK = 200;
  localparam logic [15:0] CNT_MID = 16'd0, CNT_END = 16'd0;
`endif

  always #5 clk = ~clk;

  router_in_port #(.FIFO_DEPTH(16), .PORT_WIDTH(128), .LOCAL_X(4'd2), .LOCAL_Y(4'd1)) dut (
    .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tlast(s_tlast), .req(req), .gnt(gnt), .out_msg(out_msg), .out_last(out_last),
    .full(full), .empty(empty), .level(level), .flit_cnt(flit_cnt));

  function automatic logic [127:0] mk(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] tag);
    return {8'h00, dx, dy, 8'h00, 96'h0, tag};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] d, input logic l);
    s_tvalid = 1; s_tdata = d; s_tlast = l;
    tick;
    s_tvalid = 0;
  endtask

  task automatic pop1;
    gnt = 5'h1f;
    tick;
    gnt = 0;
  endtask

  initial begin
    #3;
    chk("rst_tready", s_tready, 1);
    chk("rst_req", req, 0);
    chk("rst_msg", out_msg, 0);
    chk("rst_last", out_last, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_cnt", flit_cnt, 0);
    @(posedge clk); #1 rst_n = 1;
    // single flit, east, grant held
    gnt = 5'b00100;
    push(mk(3, 1, 1), 1);
    chk("east_req", req, 5'b00100);
    chk("east_msg", out_msg, mk(3, 1, 1));
    chk("east_last", out_last, 1);
    tick;
    chk("east_empty", empty, 1);
    chk("east_req0", req, 0);
    gnt = 0;
    // route variants
    push(mk(2, 0, 2), 1);
    chk("south_req", req, 5'b01000);
    gnt = 5'b00100;
    tick;
    chk("stray_gnt_level", level, 1);
    gnt = 0;
    pop1;
    chk("south_popped", empty, 1);
    push(mk(2, 1, 3), 1);
    chk("local_req", req, 5'b00001);
    pop1;
    push(mk(0, 3, 4), 1);
    chk("west_req", req, 5'b10000);
    pop1;
    // packet lock: body header decodes west but must follow east
    push(mk(3, 1, 5), 0);
    chk("pkt_head_req", req, 5'b00100);
    pop1;
    chk("pkt_body_empty_req", req, 0);
    push(mk(0, 1, 6), 0);
    chk("pkt_body_req", req, 5'b00100);
    push(mk(0, 1, 7), 1);
    gnt = 5'b00100;
    tick;
    chk("pkt_tail_req", req, 5'b00100);
    chk("pkt_tail_last", out_last, 1);
    chk("pkt_tail_msg", out_msg, mk(0, 1, 7));
    tick;
    chk("pkt_done_empty", empty, 1);
    gnt = 0;
    push(mk(2, 1, 8), 1);
    chk("redecode_req", req, 5'b00001);
    pop1;
    // fill to full
    for (int i = 0; i < 16; i++) push(mk(3, 1, 8'(i)), 1);
    chk("fill_full", full, 1);
    chk("fill_tready", s_tready, 0);
    chk("fill_level", level, 16);
    s_tvalid = 1; s_tdata = mk(3, 1, 99); s_tlast = 1; gnt = 5'b00100;
    tick;
    chk("full_pop_level", level, 15);
    chk("full_pop_msg", out_msg, mk(3, 1, 1));
    tick;
    chk("pushpop_level", level, 15);
    chk("pushpop_msg", out_msg, mk(3, 1, 2));
    s_tvalid = 0;
    for (int i = 2; i < 16; i++) begin
      chk("drain_msg", out_msg, mk(3, 1, 8'(i)));
      tick;
    end
    chk("drain_last_msg", out_msg, mk(3, 1, 99));
    tick;
    chk("drain_empty", empty, 1);
    chk("drain_level", level, 0);
    gnt = 0;
    push(mk(1, 1, 8'h55), 1);
    chk("wrap_msg", out_msg, mk(1, 1, 8'h55));
    chk("wrap_req", req, 5'b10000);
    pop1;
    // async reset mid-packet
    push(mk(3, 1, 10), 0);
    for (int i = 0; i < 5; i++) push(mk(0, 1, 8'(11 + i)), 0);
    gnt = 5'b00100;
    tick;
    gnt = 0;
    chk("mid_level", level, 5);
    chk("mid_req", req, 5'b00100);
    rst_n = 0;
    #1;
    chk("arst_req", req, 0);
    chk("arst_level", level, 0);
    chk("arst_tready", s_tready, 1);
    chk("arst_empty", empty, 1);
    @(posedge clk); #1 rst_n = 1;
    push(mk(2, 0, 20), 1);
    chk("post_rst_head", req, 5'b01000);
    pop1;
    chk("cnt_mid", flit_cnt, CNT_MID);
    // sustained single-flit traffic for the counter
    s_tvalid = 1; s_tdata = mk(3, 1, 0); s_tlast = 1; gnt = 5'b00100;
    repeat (N_BULK) tick;
    s_tvalid = 0;
    tick;
    gnt = 0;
    chk("bulk_empty", empty, 1);
    chk("cnt_end", flit_cnt, CNT_END);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
